// File: rtl/shift_nib_in_byte_if.sv
// Nibble receiver bus: host-side strobe/data plus consumer-side holding register handshake.
`timescale 1ns/1ps
interface shift_nib_in_byte_if #(
    parameter int unsigned WORD_NIBBLES = 2
);
    logic                      select;
    logic                      nclk;
    logic [3:0]                nin;
    logic [4*WORD_NIBBLES-1:0] data;
    logic                      data_valid;
    logic                      data_ack;
    logic                      busy;
    logic                      overrun;

    modport master (
        output select,
        output nclk,
        output nin,
        output data_ack,
        input  data,
        input  data_valid,
        input  busy,
        input  overrun
    );

    modport slave (
        input  select,
        input  nclk,
        input  nin,
        input  data_ack,
        output data,
        output data_valid,
        output busy,
        output overrun
    );
endinterface

// File: rtl/shift_nib_in_byte.sv
// Nibble-wide receiver: synchronises an asynchronous strobe/data bus, shifts
// nibbles in high-first and presents completed words in a one-deep holding
// register with valid/ack handshake and a sticky overrun flag.
`timescale 1ns/1ps
module shift_nib_in_byte #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned WORD_NIBBLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    shift_nib_in_byte_if.slave  bus
);

    localparam int unsigned W  = 4 * WORD_NIBBLES;
    localparam int unsigned CW = $clog2(WORD_NIBBLES + 1);
    localparam logic [CW-1:0] LAST = CW'(WORD_NIBBLES - 1);

    typedef enum logic {
        IDLE,
        ASSEMBLE
    } state_t;

    logic [SYNC_STAGES-1:0]      nclk_sync_q;
    logic [SYNC_STAGES-1:0][3:0] nin_sync_q;
    logic                        nclk_prev_q;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [W-1:0]    data_q, data_d;
    logic            valid_q, valid_d;
    logic            overrun_q, overrun_d;
    logic            select_prev_q;

    logic            nclk_s;
    logic [3:0]      nin_s;
    logic            strobe_edge;
    logic            take;
    logic            complete;
    logic [W+3:0]    shift_ext;
    logic [W-1:0]    assembled;

    // Strobe and data share identical flop chains so data stays aligned with the strobe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            nclk_sync_q <= '0;
            nin_sync_q  <= '0;
            nclk_prev_q <= 1'b0;
        end else begin
            nclk_sync_q <= {nclk_sync_q[SYNC_STAGES-2:0], bus.nclk};
            nin_sync_q  <= {nin_sync_q[SYNC_STAGES-2:0], bus.nin};
            nclk_prev_q <= nclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign nclk_s      = nclk_sync_q[SYNC_STAGES-1];
    assign nin_s       = nin_sync_q[SYNC_STAGES-1];
    assign strobe_edge = nclk_s & ~nclk_prev_q;
    assign take        = strobe_edge & bus.select;
    assign complete    = take && (count_q == LAST);
    // Widen before truncating so the shift also works for single-nibble words.
    assign shift_ext   = {shift_q, nin_s};
    assign assembled   = shift_ext[W-1:0];

    // Register all assembly, holding and flag state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            count_q       <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            overrun_q     <= 1'b0;
            select_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            overrun_q     <= overrun_d;
            select_prev_q <= bus.select;
        end
    end

    // Next-state: nibble assembly, word hand-off to the holding register, overrun tracking.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (!bus.select) begin
            state_d = IDLE;
            count_d = '0;
            shift_d = '0;
            if (select_prev_q) begin
                overrun_d = 1'b0;
            end
        end else if (take) begin
            shift_d = assembled;
            if (complete) begin
                state_d = IDLE;
                count_d = '0;
            end else begin
                state_d = ASSEMBLE;
                count_d = count_q + 1'b1;
            end
        end

        if (complete) begin
            if (!valid_q || bus.data_ack) begin
                data_d  = assembled;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (bus.data_ack) begin
            valid_d = 1'b0;
        end
    end

    assign bus.data       = data_q;
    assign bus.data_valid = valid_q;
    assign bus.busy       = (count_q != '0);
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_shift_nib_in_byte.sv
// Bench for shift_nib_in_byte: directed corner sequences, a vector table and
// a scoreboard that checks every word appearing in the holding register.
`timescale 1ns/1ps
module tb_shift_nib_in_byte;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_pass;
    logic mon_en;
    logic dv_prev;
    logic [7:0] data_prev;
    logic [7:0] sb[$];

    typedef struct {
        logic [3:0] hi;
        logic [3:0] lo;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[6];

    shift_nib_in_byte_if #(.WORD_NIBBLES(2)) bus();

    shift_nib_in_byte #(
        .SYNC_STAGES (2),
        .WORD_NIBBLES(2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: every newly loaded word must match the oldest expected word.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.data_valid && (!dv_prev || bus.data != data_prev)) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_unexpected: got 0x%0h expected no word", bus.data);
                end else begin
                    check("sb_word", bus.data, sb.pop_front());
                end
            end
        end
        dv_prev   <= bus.data_valid;
        data_prev <= bus.data;
    end

    // Raise the strobe with new data; returns inside the cycle where the edge is detected.
    task automatic rise_to_edge(input logic [3:0] n);
        @(negedge clk);
        bus.nin  = n;
        bus.nclk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic finish_strobe();
        repeat (3) @(negedge clk);
        bus.nclk = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_nib(input logic [3:0] n);
        rise_to_edge(n);
        @(negedge clk);
        finish_strobe();
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        bus.data_ack = 1'b1;
        @(negedge clk);
        bus.data_ack = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        mon_en   = 1'b0;
        dv_prev  = 1'b0;
        data_prev = '0;
        vecs[0] = '{hi: 4'h0, lo: 4'h0, exp: 8'h00};
        vecs[1] = '{hi: 4'hF, lo: 4'hF, exp: 8'hFF};
        vecs[2] = '{hi: 4'h1, lo: 4'hE, exp: 8'h1E};
        vecs[3] = '{hi: 4'hC, lo: 4'h3, exp: 8'hC3};
        vecs[4] = '{hi: 4'h9, lo: 4'h6, exp: 8'h96};
        vecs[5] = '{hi: 4'h5, lo: 4'hA, exp: 8'h5A};

        reset_n      = 1'b0;
        bus.select   = 1'b0;
        bus.nclk     = 1'b0;
        bus.nin      = 4'h0;
        bus.data_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", bus.data, 8'h00);
        check("rst_valid", bus.data_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_overrun", bus.overrun, 1'b0);
        reset_n    = 1'b1;
        mon_en     = 1'b1;
        bus.select = 1'b1;

        // Basic word, with exact data_valid latency on the final nibble.
        sb.push_back(8'hA5);
        send_nib(4'hA);
        check("t1_busy_mid", bus.busy, 1'b1);
        rise_to_edge(4'h5);
        check("t1_valid_at_edge", bus.data_valid, 1'b0);
        @(negedge clk);
        check("t1_valid_after", bus.data_valid, 1'b1);
        check("t1_data", bus.data, 8'hA5);
        check("t1_busy_done", bus.busy, 1'b0);
        finish_strobe();

        // Overrun while the holding register is full.
        send_nib(4'h1); send_nib(4'h2);
        send_nib(4'h3); send_nib(4'h4);
        check("t2_data_kept", bus.data, 8'hA5);
        check("t2_overrun", bus.overrun, 1'b1);
        check("t2_valid", bus.data_valid, 1'b1);
        ack_pulse();
        check("t2_ack_valid", bus.data_valid, 1'b0);
        check("t2_ack_data", bus.data, 8'hA5);
        check("t2_overrun_sticky", bus.overrun, 1'b1);
        @(negedge clk);
        bus.select = 1'b0;
        @(negedge clk);
        check("t2_overrun_clr", bus.overrun, 1'b0);
        bus.select = 1'b1;

        // Completion coinciding with ack of the previous word.
        sb.push_back(8'h66);
        send_nib(4'h6); send_nib(4'h6);
        check("t3_first_valid", bus.data_valid, 1'b1);
        sb.push_back(8'h7E);
        send_nib(4'h7);
        rise_to_edge(4'hE);
        bus.data_ack = 1'b1;
        @(negedge clk);
        bus.data_ack = 1'b0;
        check("t3_valid", bus.data_valid, 1'b1);
        check("t3_data", bus.data, 8'h7E);
        check("t3_overrun", bus.overrun, 1'b0);
        finish_strobe();
        ack_pulse();
        check("t3_ack", bus.data_valid, 1'b0);

        // Deselect aborts a partial word.
        send_nib(4'hF);
        check("t4_busy", bus.busy, 1'b1);
        @(negedge clk);
        bus.select = 1'b0;
        @(negedge clk);
        check("t4_busy_desel", bus.busy, 1'b0);
        bus.select = 1'b1;
        sb.push_back(8'h3C);
        send_nib(4'h3); send_nib(4'hC);
        check("t4_data", bus.data, 8'h3C);
        check("t4_valid", bus.data_valid, 1'b1);
        check("t4_busy_done", bus.busy, 1'b0);

        // Reset mid-word discards the partial word and the held word.
        send_nib(4'h9);
        check("t5_busy", bus.busy, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("t5_rst_valid", bus.data_valid, 1'b0);
        check("t5_rst_busy", bus.busy, 1'b0);
        check("t5_rst_data", bus.data, 8'h00);
        sb.push_back(8'h42);
        send_nib(4'h4); send_nib(4'h2);
        check("t5_data", bus.data, 8'h42);
        check("t5_valid", bus.data_valid, 1'b1);
        ack_pulse();

        // Data wiggle with strobe low and sub-cycle glitches between clock edges.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.nin = 4'($urandom_range(0, 15));
            if (i % 2 == 0) begin
                bus.nclk = 1'b1;
                #2;
                bus.nclk = 1'b0;
            end
        end
        repeat (4) @(negedge clk);
        check("t6_busy", bus.busy, 1'b0);
        check("t6_valid", bus.data_valid, 1'b0);

        // Vector table.
        for (int i = 0; i < 6; i++) begin
            sb.push_back(vecs[i].exp);
            send_nib(vecs[i].hi);
            check("vec_busy", bus.busy, 1'b1);
            send_nib(vecs[i].lo);
            check("vec_data", bus.data, vecs[i].exp);
            check("vec_valid", bus.data_valid, 1'b1);
            check("vec_overrun", bus.overrun, 1'b0);
            ack_pulse();
        end

        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
